// File: rtl/exp_pulse_gen.sv
// exp_pulse_gen: periodic exponentially decaying pulse train on a baseline, AXI-Stream master
module exp_pulse_gen #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int DAC_WIDTH = 14
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [12:0]                 amplitude,
  input  logic [4:0]                  decay_shift,
  input  logic [31:0]                 period,
  input  logic signed [13:0]          baseline,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [31:0]                 pulse_count,
  output logic                        busy
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic signed [19:0] YMAX = 20'((1 << (DAC_WIDTH - 1)) - 1);
  localparam logic signed [19:0] YMIN = -YMAX - 20'sd1;
  state_t state_q;
  logic [31:0] acc_q, cnt_q, pc_q, dec, acc_d, cnt_d;
  logic [32:0] pile;
  logic fire;
  logic signed [19:0] y, y_c;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  // decay, pulse-start decision, next accumulator and clamped output sample
  always_comb begin
    dec = acc_q - (acc_q >> decay_shift);
    pile = {1'b0, dec} + {4'b0, amplitude, 16'b0};
    fire = (period != 32'd0) && ({1'b0, cnt_q} + 33'd1 >= {1'b0, period});
    cnt_d = fire ? 32'd0 : (&cnt_q ? cnt_q : cnt_q + 32'd1);
    acc_d = state_q == IDLE ? {3'b0, amplitude, 16'b0} : fire ? (pile[32] ? '1 : pile[31:0]) : dec;
    y = {{6{baseline[13]}}, baseline} + {4'b0, acc_d[31:16]};
    y_c = y > YMAX ? YMAX : y < YMIN ? YMIN : y;
    tdata_d = AXIS_TDATA_WIDTH'(y_c);
  end
  // IDLE/RUN controller; in RUN tvalid is always high so a transfer is just tready
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      pc_q <= '0;
      tdata_q <= '0;
    end else if (state_q == IDLE) begin
      if (enable) begin
        state_q <= RUN;
        acc_q <= acc_d;
        cnt_q <= '0;
        pc_q <= pc_q + 32'd1;
        tdata_q <= tdata_d;
      end
    end else if (m_axis_tready) begin
      if (!enable) state_q <= IDLE;
      else begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        pc_q <= pc_q + {31'b0, fire};
        tdata_q <= tdata_d;
      end
    end
  assign m_axis_tvalid = state_q == RUN;
  assign busy = state_q == RUN;
  assign m_axis_tdata = tdata_q;
  assign pulse_count = pc_q;
endmodule

// File: tb/tb_exp_pulse_gen.sv
// tb_exp_pulse_gen: directed stimulus checked against a per-beat arithmetic model plus literal expectations
module tb_exp_pulse_gen;
  logic clk = 0;
  logic reset = 1;
  logic enable = 0;
  logic m_axis_tready = 1;
  logic [12:0] amplitude = 0;
  logic [4:0] decay_shift = 0;
  logic [31:0] period = 0;
  logic signed [13:0] baseline = 0;
  logic m_axis_tvalid, busy;
  logic [15:0] m_axis_tdata;
  logic [31:0] pulse_count;
  int checks = 0;
  int errors = 0;
  bit m_live = 0;
  bit m_run = 0;
  longint unsigned m_acc = 0;
  longint unsigned m_cnt = 0;
  longint unsigned m_d = 0;
  logic [31:0] m_pc = 0;
  int m_y = 0;

  exp_pulse_gen #(.AXIS_TDATA_WIDTH(16), .DAC_WIDTH(14)) dut (
    .clk(clk), .reset(reset), .enable(enable), .amplitude(amplitude),
    .decay_shift(decay_shift), .period(period), .baseline(baseline),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .pulse_count(pulse_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int ymodel(input longint unsigned a);
    int v;
    v = int'(baseline) + int'(a >> 16);
    return v > 8191 ? 8191 : (v < -8192 ? -8192 : v);
  endfunction

  // sample-level model: one update per clock from the inputs seen at the edge
  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_run = 0; m_acc = 0; m_cnt = 0; m_pc = 0; m_y = 0;
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1;
        m_acc = 64'(amplitude) << 16;
        m_cnt = 0;
        m_pc = m_pc + 1;
        m_y = ymodel(m_acc);
      end
    end else if (m_axis_tready) begin
      if (!enable) m_run = 0;
      else begin
        m_d = m_acc - (m_acc >> decay_shift);
        if (period != 0 && m_cnt + 1 >= 64'(period)) begin
          m_acc = m_d + (64'(amplitude) << 16);
          if (m_acc > 64'hFFFF_FFFF) m_acc = 64'hFFFF_FFFF;
          m_cnt = 0;
          m_pc = m_pc + 1;
        end else begin
          m_acc = m_d;
          if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        m_y = ymodel(m_acc);
      end
    end
  end

  always @(negedge clk)
    if (m_live) begin
      check("tvalid", m_axis_tvalid, m_run);
      check("busy", busy, m_run);
      check("pulse_count", pulse_count, m_pc);
      check("tdata", $signed(m_axis_tdata), m_y);
    end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    step(2);
    reset = 0;
    amplitude = 1000; decay_shift = 4; baseline = 0; period = 0; enable = 1;
    step(1); check("dec_y0", $signed(m_axis_tdata), 1000); check("dec_pc", pulse_count, 1);
    step(1); check("dec_y1", $signed(m_axis_tdata), 937);
    step(1); check("dec_y2", $signed(m_axis_tdata), 878);
    step(200); check("dec_end", $signed(m_axis_tdata), 0); check("dec_pc_end", pulse_count, 1);
    enable = 0;
    step(1); check("drop_valid", m_axis_tvalid, 0);
    amplitude = 500; decay_shift = 0; period = 4; baseline = -100; enable = 1;
    for (int i = 0; i < 8; i++) begin
      step(1); check("per_y", $signed(m_axis_tdata), (i % 4 == 0) ? 400 : -100);
    end
    check("per_pc", pulse_count, 3);
    enable = 0;
    step(1);
    baseline = 8000; amplitude = 1000; decay_shift = 10; period = 2; enable = 1;
    for (int i = 0; i < 200; i++) begin
      step(1); check("clamp_y", $signed(m_axis_tdata), 8191);
      if (i == 19) check("clamp_pc20", pulse_count, 13);
    end
    check("clamp_pc200", pulse_count, 103);
    enable = 0;
    step(1);
    baseline = 0; amplitude = 1000; decay_shift = 4; period = 0; enable = 1;
    step(2); check("bp_y", $signed(m_axis_tdata), 937);
    m_axis_tready = 0;
    step(1); check("bp_hold1", $signed(m_axis_tdata), 937); check("bp_valid1", m_axis_tvalid, 1);
    enable = 0;
    step(1); check("bp_hold2", $signed(m_axis_tdata), 937); check("bp_valid2", m_axis_tvalid, 1);
    step(1); check("bp_hold3", $signed(m_axis_tdata), 937); check("bp_busy3", busy, 1);
    m_axis_tready = 1;
    step(1); check("bp_valid_end", m_axis_tvalid, 0); check("bp_busy_end", busy, 0);
    enable = 1;
    step(3);
    m_axis_tready = 0; reset = 1;
    step(1); check("rst_valid", m_axis_tvalid, 0); check("rst_tdata", $signed(m_axis_tdata), 0);
    check("rst_pc", pulse_count, 0);
    reset = 0; baseline = -50; amplitude = 300; m_axis_tready = 1;
    step(1); check("rst_first", $signed(m_axis_tdata), 250); check("rst_first_pc", pulse_count, 1);
    enable = 0;
    step(1);
    baseline = 0; amplitude = 1000; decay_shift = 4; period = 100; enable = 1;
    step(1); check("live_pc1", pulse_count, 2);
    step(50); check("live_pc51", pulse_count, 2);
    period = 10;
    step(1); check("live_retrig", pulse_count, 3);
    step(9); check("live_pc61", pulse_count, 3);
    step(1); check("live_pc62", pulse_count, 4);
    step(10); check("live_pc72", pulse_count, 5);
    enable = 0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
